// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART-style instruction memory loader: state encoding,
// frame sync byte and parameter defaults.
package imem_loader_pkg;

   localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
   localparam int unsigned DEF_MAX_WORDS   = 64;
   localparam int unsigned DEF_TIMEOUT_CYC = 100000;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StCount,
      StData,
      StCheck,
      StDone,
      StErr
   } state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Shifts bytes MSB-first into a 32-bit word, flags the 4th byte of each word and keeps
// a running XOR of every byte accepted since the last clear.
module byte_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        valid,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_done,
   output logic [7:0]  csum
);

   logic [23:0] shift_q;
   logic [1:0]  cnt_q;
   logic [7:0]  csum_q;

   // word includes the byte being accepted this cycle, so it is complete when word_done is high
   assign word      = {shift_q, data};
   assign word_done = valid && (cnt_q == 2'd3);
   assign csum      = csum_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         shift_q <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
      end else if (valid) begin
         shift_q <= word[23:0];
         cnt_q   <= cnt_q + 2'd1;
         csum_q  <= csum_q ^ data;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed byte stream (sync, count, words, XOR checksum) and writes the words
// into instruction memory, holding the CPU in reset until a frame loads cleanly.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS   = DEF_MAX_WORDS,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        we,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int unsigned IW = $clog2(MAX_WORDS + 1);
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, n_q;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            asm_clear, asm_valid, word_done;
   logic [31:0]     asm_word;
   logic [7:0]      csum;
   logic            counting, byte_accept, tmo_expired, count_ok, last_word;

   byte_word_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .valid     (asm_valid),
      .data      (rx_data),
      .word      (asm_word),
      .word_done (word_done),
      .csum      (csum)
   );

   assign counting    = state_q inside {StCount, StData, StCheck};
   assign byte_accept = counting && rx_valid;
   assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYC - 1)) && !rx_valid;
   assign count_ok    = (rx_data != 8'd0) && (32'(rx_data) <= MAX_WORDS);
   assign last_word   = (idx_q == n_q - IW'(1));

   always_comb begin
      state_d   = state_q;
      asm_clear = 1'b0;
      asm_valid = 1'b0;
      unique case (state_q)
         StIdle, StDone, StErr: if (start) state_d = StSync;
         StSync: if (rx_valid && rx_data == SYNC_BYTE) state_d = StCount;
         StCount: begin
            if (rx_valid) begin
               if (count_ok) begin
                  state_d   = StData;
                  asm_clear = 1'b1;
               end else begin
                  state_d = StErr;
               end
            end else if (tmo_expired) begin
               state_d = StErr;
            end
         end
         StData: begin
            if (rx_valid) begin
               asm_valid = 1'b1;
               if (word_done && last_word) state_d = StCheck;
            end else if (tmo_expired) begin
               state_d = StErr;
            end
         end
         StCheck: begin
            if (rx_valid) state_d = (rx_data == csum) ? StDone : StErr;
            else if (tmo_expired) state_d = StErr;
         end
         default: state_d = StIdle;
      endcase
   end

   // Idle-cycle counter restarts on every accepted byte and on every state change
   always_comb begin
      tmo_d = '0;
      if (counting && !byte_accept && state_d == state_q) tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         n_q      <= '0;
         tmo_q    <= '0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         cpu_hold <= (state_d != StDone);
         done     <= (state_d == StDone);
         error    <= (state_d == StErr);
         we       <= asm_valid && word_done;
         if (asm_clear) begin
            idx_q <= '0;
            n_q   <= IW'(rx_data);
         end
         if (asm_valid && word_done) begin
            waddr <= 32'(idx_q) << 2;
            wdata <= asm_word;
            idx_q <= idx_q + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table for complete frames plus hand-written
// reset-mid-frame and inter-byte timeout sequences.
module tb_imem_loader;

   localparam int unsigned TMO = 40;

   logic        clk = 1'b0;
   logic        reset, start, rx_valid;
   logic [7:0]  rx_data;
   logic        we, cpu_hold, done, error;
   logic [31:0] waddr, wdata;

   int checks = 0;
   int errors = 0;

   imem_loader #(
      .MAX_WORDS   (64),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        v;
      logic [7:0]  d;
      logic        we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic        hold;
      logic        dn;
      logic        er;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic st, input logic v, input logic [7:0] d, input logic e_we,
                      input logic [31:0] wa, input logic [31:0] wd, input logic hold,
                      input logic dn, input logic er);
      vec_t t;
      t.st = st; t.v = v; t.d = d; t.we = e_we; t.wa = wa; t.wd = wd;
      t.hold = hold; t.dn = dn; t.er = er;
      vq.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic v, input logic [7:0] d);
      start    = st;
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic check_outs(input string tag, input logic e_we, input logic [31:0] wa,
                             input logic [31:0] wd, input logic hold, input logic dn,
                             input logic er);
      check({tag, ".we"}, 32'(we), 32'(e_we));
      check({tag, ".waddr"}, waddr, wa);
      check({tag, ".wdata"}, wdata, wd);
      check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
      check({tag, ".done"}, 32'(done), 32'(dn));
      check({tag, ".error"}, 32'(error), 32'(er));
   endtask

   localparam logic [31:0] W1 = 32'h0800_0003;
   localparam logic [31:0] W2 = 32'h2008_0040;
   localparam logic [31:0] WB = 32'hDEAD_BEEF;

   initial begin
      int we_seen;
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;

      // Good two-word frame with a leading junk byte in SYNC
      add(1, 0, 8'h00, 0, 0, 0, 1, 0, 0);
      add(0, 1, 8'h11, 0, 0, 0, 1, 0, 0);
      add(0, 1, 8'hA5, 0, 0, 0, 1, 0, 0);
      add(0, 1, 8'h02, 0, 0, 0, 1, 0, 0);
      add(0, 1, 8'h08, 0, 0, 0, 1, 0, 0);
      add(0, 1, 8'h00, 0, 0, 0, 1, 0, 0);
      add(0, 1, 8'h00, 0, 0, 0, 1, 0, 0);
      add(0, 1, 8'h03, 1, 0, W1, 1, 0, 0);
      add(0, 1, 8'h20, 0, 0, W1, 1, 0, 0);
      add(0, 1, 8'h08, 0, 0, W1, 1, 0, 0);
      add(0, 1, 8'h00, 0, 0, W1, 1, 0, 0);
      add(0, 1, 8'h40, 1, 4, W2, 1, 0, 0);
      add(0, 1, 8'h63, 0, 4, W2, 0, 1, 0);
      add(0, 1, 8'h11, 0, 4, W2, 0, 1, 0);
      add(0, 0, 8'h00, 0, 4, W2, 0, 1, 0);
      // Restart from DONE: one-word frame overwrites from address 0
      add(1, 0, 8'h00, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hA5, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h01, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hDE, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hAD, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hBE, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hEF, 1, 0, WB, 1, 0, 0);
      add(0, 1, 8'h22, 0, 0, WB, 0, 1, 0);
      // Same two-word frame with a bad checksum: writes happen, then ERR
      add(1, 0, 8'h00, 0, 0, WB, 1, 0, 0);
      add(0, 1, 8'hA5, 0, 0, WB, 1, 0, 0);
      add(0, 1, 8'h02, 0, 0, WB, 1, 0, 0);
      add(0, 1, 8'h08, 0, 0, WB, 1, 0, 0);
      add(0, 1, 8'h00, 0, 0, WB, 1, 0, 0);
      add(0, 1, 8'h00, 0, 0, WB, 1, 0, 0);
      add(0, 1, 8'h03, 1, 0, W1, 1, 0, 0);
      add(0, 1, 8'h20, 0, 0, W1, 1, 0, 0);
      add(0, 1, 8'h08, 0, 0, W1, 1, 0, 0);
      add(0, 1, 8'h00, 0, 0, W1, 1, 0, 0);
      add(0, 1, 8'h40, 1, 4, W2, 1, 0, 0);
      add(0, 1, 8'h62, 0, 4, W2, 1, 0, 1);
      add(0, 1, 8'hA5, 0, 4, W2, 1, 0, 1);
      // Count 0 and count 65 fail immediately; count 64 is accepted
      add(1, 0, 8'h00, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hA5, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h00, 0, 4, W2, 1, 0, 1);
      add(1, 0, 8'h00, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hA5, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h41, 0, 4, W2, 1, 0, 1);
      add(1, 0, 8'h00, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'hA5, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h40, 0, 4, W2, 1, 0, 0);
      // start in DATA is ignored, so the next four bytes still form word 0
      add(1, 0, 8'h00, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h01, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h02, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h03, 0, 4, W2, 1, 0, 0);
      add(0, 1, 8'h04, 1, 0, 32'h0102_0304, 1, 0, 0);

      foreach (vq[i]) begin
         step(vq[i].st, vq[i].v, vq[i].d);
         check_outs($sformatf("vec%0d", i), vq[i].we, vq[i].wa, vq[i].wd, vq[i].hold,
                    vq[i].dn, vq[i].er);
      end

      // Reset after two data bytes of word 1, then stray bytes must not write
      step(0, 1, 8'h05);
      step(0, 1, 8'h06);
      reset = 1'b1;
      step(0, 1, 8'h07);
      reset = 1'b0;
      check_outs("midreset", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      we_seen = 0;
      foreach (vq[i]) begin
         if (i < 12) begin
            step(0, vq[i].v, vq[i].d);
            if (we) we_seen++;
         end
      end
      check("midreset.no_we", 32'(we_seen), 32'd0);
      check_outs("midreset.after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Inter-byte timeout in DATA
      step(1, 0, 8'h00);
      step(0, 1, 8'hA5);
      step(0, 1, 8'h01);
      step(0, 1, 8'h08);
      step(0, 1, 8'h00);
      we_seen = 0;
      repeat (TMO - 1) begin
         step(0, 0, 8'h00);
         if (we) we_seen++;
      end
      check("tmo.early_error", 32'(error), 32'd0);
      step(0, 0, 8'h00);
      check_outs("tmo", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      check("tmo.no_we", 32'(we_seen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
